// File: rtl/bip_program_loader.sv
// bip_program_loader: receives 3-byte frames from the UART receiver, packs
// each into a 16-bit BIP instruction word {opcode[4:0], operand[10:0]},
// writes the words to consecutive program memory addresses, echoes the low
// address byte of every stored word and releases the CPU once HALT is stored.
// Any framing error, overrun or program overflow sends ACK_ERR once and parks.

module bip_program_loader #(
    parameter int         PROG_DEPTH = 2048,
    parameter int         ADDR_W     = 11,
    parameter logic [7:0] ACK_ERR    = 8'hEE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_wdata,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_GET_OP,
        S_GET_HI,
        S_GET_LO,
        S_WRITE,
        S_ACK,
        S_DONE,
        S_ERR_TX,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_opcode;
    logic [2:0]        r_operandHi;
    logic              r_overrun;
    logic [7:0]        r_txData;
    logic              r_txValid;
    logic              r_progWe;
    logic [ADDR_W-1:0] r_progAddr;
    logic [15:0]       r_progWdata;
    logic              r_loadDone;
    logic              r_loadErr;

    logic w_byteOk;
    logic w_isHalt;
    logic w_lastAddr;
    logic w_txFire;
    logic w_overrun;

    // B0 and B1 share one legality rule: only the low three bits may be set
    // (for B0 that is exactly "upper bits clear and opcode <= 7").
    assign w_byteOk   = (rx_data[7:3] == 5'd0);
    assign w_isHalt   = (r_progWdata[15:11] == 5'd0);
    assign w_lastAddr = (r_progAddr == LAST_ADDR);
    assign w_txFire   = r_txValid & tx_ready;
    // A byte arriving on the very edge that completes the ack still counts.
    assign w_overrun  = r_overrun | rx_valid;

    assign tx_data    = r_txData;
    assign tx_valid   = r_txValid;
    assign prog_we    = r_progWe;
    assign prog_addr  = r_progAddr;
    assign prog_wdata = r_progWdata;
    assign load_done  = r_loadDone;
    assign load_err   = r_loadErr;

    // Loader FSM: frame assembly, memory write, ack handshake and error exit, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_GET_OP;
            r_addr      <= '0;
            r_opcode    <= '0;
            r_operandHi <= '0;
            r_overrun   <= 1'b0;
            r_txData    <= '0;
            r_txValid   <= 1'b0;
            r_progWe    <= 1'b0;
            r_progAddr  <= '0;
            r_progWdata <= '0;
            r_loadDone  <= 1'b0;
            r_loadErr   <= 1'b0;
        end else begin
            r_progWe <= 1'b0;
            case (r_state)
                S_GET_OP: begin
                    if (rx_valid) begin
                        if (w_byteOk) begin
                            r_opcode <= rx_data[4:0];
                            r_state  <= S_GET_HI;
                        end else begin
                            r_loadErr <= 1'b1;
                            r_state   <= S_ERR_TX;
                        end
                    end
                end
                S_GET_HI: begin
                    if (rx_valid) begin
                        if (w_byteOk) begin
                            r_operandHi <= rx_data[2:0];
                            r_state     <= S_GET_LO;
                        end else begin
                            r_loadErr <= 1'b1;
                            r_state   <= S_ERR_TX;
                        end
                    end
                end
                S_GET_LO: begin
                    if (rx_valid) begin
                        r_progWe    <= 1'b1;
                        r_progAddr  <= r_addr;
                        r_progWdata <= {r_opcode, r_operandHi, rx_data};
                        r_overrun   <= 1'b0;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_addr    <= r_addr + ADDR_ONE;
                    r_txData  <= 8'(r_progAddr);
                    r_txValid <= 1'b1;
                    if (rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_txFire) begin
                        r_txValid <= 1'b0;
                        if (w_overrun) begin
                            r_loadErr <= 1'b1;
                            r_state   <= S_ERR_TX;
                        end else if (w_isHalt) begin
                            r_loadDone <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_lastAddr) begin
                            r_loadErr <= 1'b1;
                            r_state   <= S_ERR_TX;
                        end else begin
                            r_state <= S_GET_OP;
                        end
                    end
                end
                S_ERR_TX: begin
                    // Offer ACK_ERR once the previous offer has cleared, then park after it is taken.
                    if (!r_txValid) begin
                        r_txData  <= ACK_ERR;
                        r_txValid <= 1'b1;
                    end else if (tx_ready) begin
                        r_txValid <= 1'b0;
                        r_state   <= S_ERR;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_GET_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_program_loader.sv
// tb_bip_program_loader: drives byte frames into two loaders (full depth and
// a 4-word one) and checks writes, ack bytes and status flags against a
// frame-level reference model and directed expectations.

module tb_bip_program_loader;

    localparam int BIG_DEPTH   = 2048;
    localparam int SMALL_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;

    logic [7:0]  bTxData;
    logic        bTxValid;
    logic        bWe;
    logic [10:0] bAddr;
    logic [15:0] bWdata;
    logic        bDone;
    logic        bErr;

    logic [7:0]  sTxData;
    logic        sTxValid;
    logic        sWe;
    logic [10:0] sAddr;
    logic [15:0] sWdata;
    logic        sDone;
    logic        sErr;

    int testCount;
    int failCount;
    bit readyRandom;

    logic [15:0] bW[$];
    logic [10:0] bA[$];
    logic [7:0]  bT[$];
    logic [15:0] sW[$];
    logic [10:0] sA[$];
    logic [7:0]  sT[$];
    int bwBase, btBase, swBase, stBase;

    logic [7:0]  stim[$];
    logic [7:0]  sent[$];
    logic [15:0] mW[$];
    logic [7:0]  mT[$];
    bit          mDone;
    bit          mErr;

    bip_program_loader #(.PROG_DEPTH(BIG_DEPTH), .ADDR_W(11), .ACK_ERR(8'hEE)) dutBig (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(bTxData), .tx_valid(bTxValid), .tx_ready(tx_ready),
        .prog_we(bWe), .prog_addr(bAddr), .prog_wdata(bWdata),
        .load_done(bDone), .load_err(bErr)
    );

    bip_program_loader #(.PROG_DEPTH(SMALL_DEPTH), .ADDR_W(11), .ACK_ERR(8'hEE)) dutSmall (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(sTxData), .tx_valid(sTxValid), .tx_ready(tx_ready),
        .prog_we(sWe), .prog_addr(sAddr), .prog_wdata(sWdata),
        .load_done(sDone), .load_err(sErr)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write and every completed tx transfer of both loaders, mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bWe) begin
                bW.push_back(bWdata);
                bA.push_back(bAddr);
            end
            if (bTxValid && tx_ready) bT.push_back(bTxData);
            if (sWe) begin
                sW.push_back(sWdata);
                sA.push_back(sAddr);
            end
            if (sTxValid && tx_ready) sT.push_back(sTxData);
        end
    end

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (readyRandom) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic markBases();
        bwBase = bW.size();
        btBase = bT.size();
        swBase = sW.size();
        stBase = sT.size();
        sent.delete();
    endtask

    task automatic doReset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        markBases();
    endtask

    task automatic driveByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic flush();
        readyRandom = 1'b0;
        tx_ready    = 1'b1;
        rx_valid    = 1'b0;
        repeat (30) tick();
    endtask

    // Send the queued bytes; after each third byte wait for the ack to clear before the next frame.
    task automatic applyStimulus(input bit randomGaps);
        foreach (stim[i]) begin
            sent.push_back(stim[i]);
            driveByte(stim[i]);
            if (i % 3 == 2) begin
                int n;
                tick();
                tick();
                n = 0;
                while (bTxValid && n < 200) begin
                    tick();
                    n++;
                end
                if (bTxValid) begin
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL ack_timeout: tx_valid still %0b after %0d cycles, required 0", bTxValid, n);
                end
            end else if (randomGaps) begin
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    // Frame-level reference: walk the sent bytes three at a time and list the words and tx bytes.
    task automatic modelRun(input int depth);
        int pos;
        int addr;
        logic [7:0] op;
        logic [7:0] hi;
        mW.delete();
        mT.delete();
        mDone = 1'b0;
        mErr  = 1'b0;
        pos   = 0;
        addr  = 0;
        op    = '0;
        hi    = '0;
        foreach (sent[i]) begin
            if (mDone || mErr) break;
            if (pos < 2 && sent[i] > 8'd7) begin
                mErr = 1'b1;
                mT.push_back(8'hEE);
            end else if (pos == 0) begin
                op  = sent[i];
                pos = 1;
            end else if (pos == 1) begin
                hi  = sent[i];
                pos = 2;
            end else begin
                mW.push_back({op[4:0], hi[2:0], sent[i]});
                mT.push_back(addr[7:0]);
                if (op == 8'd0) mDone = 1'b1;
                else if (addr == depth - 1) begin
                    mErr = 1'b1;
                    mT.push_back(8'hEE);
                end else addr++;
                pos = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        testCount++;
        if ({bTxValid, bWe, bDone, bErr} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_flags_big: got %b, required 0000", {bTxValid, bWe, bDone, bErr});
        end
        testCount++;
        if ({bAddr, bWdata, bTxData} !== 35'd0) begin
            failCount++;
            $display("[TB] FAIL reset_data_big: addr %h wdata %h txdata %h, required all 0", bAddr, bWdata, bTxData);
        end
        testCount++;
        if ({sTxValid, sWe, sDone, sErr, sAddr, sWdata, sTxData} !== 39'd0) begin
            failCount++;
            $display("[TB] FAIL reset_small: got %h, required 0", {sTxValid, sWe, sDone, sErr, sAddr, sWdata, sTxData});
        end
        reset = 1'b0;
        markBases();
    endtask

    task automatic test_basic_program();
        doReset();
        tx_ready = 1'b1;
        stim = '{8'h03, 8'h00, 8'h05, 8'h05, 8'h00, 8'h03, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        applyStimulus(1'b0);
        flush();
        modelRun(BIG_DEPTH);
        testCount++;
        if (bW.size() - bwBase != mW.size()) begin
            failCount++;
            $display("[TB] FAIL basic_write_count: got %0d, required %0d", bW.size() - bwBase, mW.size());
        end else begin
            foreach (mW[k]) begin
                testCount++;
                if (bW[bwBase + k] !== mW[k] || bA[bwBase + k] !== 11'(k)) begin
                    failCount++;
                    $display("[TB] FAIL basic_write%0d: got %h@%0d, required %h@%0d", k, bW[bwBase + k], bA[bwBase + k], mW[k], k);
                end
            end
        end
        testCount++;
        if (bT.size() - btBase != mT.size()) begin
            failCount++;
            $display("[TB] FAIL basic_ack_count: got %0d, required %0d", bT.size() - btBase, mT.size());
        end else begin
            foreach (mT[k]) begin
                testCount++;
                if (bT[btBase + k] !== mT[k]) begin
                    failCount++;
                    $display("[TB] FAIL basic_ack%0d: got %h, required %h", k, bT[btBase + k], mT[k]);
                end
            end
        end
        testCount++;
        if (bDone !== 1'b1 || bErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL basic_status: done %b err %b, required 1 0", bDone, bErr);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        tx_ready = 1'b1;
        driveByte(8'h02);
        driveByte(8'h01);
        driveByte(8'hAB);
        testCount++;
        if (bWe !== 1'b1 || bWdata !== 16'h11AB || bAddr !== 11'd0 || bTxValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_write_cycle: we %b wdata %h addr %h txv %b, required 1 11ab 000 0", bWe, bWdata, bAddr, bTxValid);
        end
        tick();
        testCount++;
        if (bWe !== 1'b0 || bTxValid !== 1'b1 || bTxData !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL b2b_ack_cycle: we %b txv %b txd %h, required 0 1 00", bWe, bTxValid, bTxData);
        end
        tick();
        testCount++;
        if (bTxValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_ack_len: tx_valid %b, required 0", bTxValid);
        end
        stim = '{8'h00, 8'h00, 8'h00};
        applyStimulus(1'b0);
        flush();
        testCount++;
        if (bW.size() - bwBase != 2 || bT.size() - btBase != 2) begin
            failCount++;
            $display("[TB] FAIL b2b_counts: writes %0d acks %0d, required 2 2", bW.size() - bwBase, bT.size() - btBase);
        end else begin
            testCount++;
            if (bW[bwBase + 1] !== 16'h0000 || bA[bwBase + 1] !== 11'd1 || bT[btBase + 1] !== 8'h01) begin
                failCount++;
                $display("[TB] FAIL b2b_second: got %h@%0d ack %h, required 0000@1 ack 01", bW[bwBase + 1], bA[bwBase + 1], bT[btBase + 1]);
            end
        end
        testCount++;
        if (bDone !== 1'b1 || bErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_status: done %b err %b, required 1 0", bDone, bErr);
        end
    endtask

    task automatic test_ack_stall();
        doReset();
        tx_ready = 1'b0;
        driveByte(8'h03);
        driveByte(8'h00);
        driveByte(8'h05);
        tick();
        for (int i = 0; i < 10; i++) begin
            testCount++;
            if (bTxValid !== 1'b1 || bTxData !== 8'h00) begin
                failCount++;
                $display("[TB] FAIL stall_hold%0d: txv %b txd %h, required 1 00", i, bTxValid, bTxData);
            end
            tick();
        end
        tx_ready = 1'b1;
        tick();
        testCount++;
        if (bTxValid !== 1'b0 || bT.size() - btBase != 1) begin
            failCount++;
            $display("[TB] FAIL stall_release: txv %b transfers %0d, required 0 1", bTxValid, bT.size() - btBase);
        end
        stim = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        applyStimulus(1'b0);
        flush();
        testCount++;
        if (bW.size() - bwBase != 3 || bT.size() - btBase != 3) begin
            failCount++;
            $display("[TB] FAIL stall_counts: writes %0d acks %0d, required 3 3", bW.size() - bwBase, bT.size() - btBase);
        end else begin
            testCount++;
            if (bW[bwBase + 1] !== 16'h2803 || bA[bwBase + 1] !== 11'd1 || bT[btBase + 1] !== 8'h01) begin
                failCount++;
                $display("[TB] FAIL stall_next_word: got %h@%0d ack %h, required 2803@1 ack 01", bW[bwBase + 1], bA[bwBase + 1], bT[btBase + 1]);
            end
        end
        testCount++;
        if (bDone !== 1'b1 || bErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stall_status: done %b err %b, required 1 0", bDone, bErr);
        end
    endtask

    task automatic test_invalid_opcode();
        doReset();
        readyRandom = 1'b1;
        stim = '{8'h08, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        applyStimulus(1'b1);
        flush();
        testCount++;
        if (bW.size() - bwBase != 0) begin
            failCount++;
            $display("[TB] FAIL badop_writes: got %0d writes, required 0", bW.size() - bwBase);
        end
        testCount++;
        if (bT.size() - btBase != 1) begin
            failCount++;
            $display("[TB] FAIL badop_tx_count: got %0d bytes, required 1", bT.size() - btBase);
        end else begin
            testCount++;
            if (bT[btBase] !== 8'hEE) begin
                failCount++;
                $display("[TB] FAIL badop_tx_byte: got %h, required ee", bT[btBase]);
            end
        end
        testCount++;
        if (bErr !== 1'b1 || bDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL badop_status: err %b done %b, required 1 0", bErr, bDone);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] expT[5];
        expT = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hEE};
        doReset();
        tx_ready = 1'b1;
        stim = '{8'h04, 8'h01, 8'h23, 8'h06, 8'h07, 8'hFF, 8'h02, 8'h00, 8'h10,
                 8'h07, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02};
        applyStimulus(1'b0);
        flush();
        testCount++;
        if (sW.size() - swBase != 4) begin
            failCount++;
            $display("[TB] FAIL ovf_small_writes: got %0d, required 4", sW.size() - swBase);
        end else begin
            testCount++;
            if (sA[swBase + 3] !== 11'd3 || sW[swBase + 3] !== 16'h3B00) begin
                failCount++;
                $display("[TB] FAIL ovf_small_last: got %h@%0d, required 3b00@3", sW[swBase + 3], sA[swBase + 3]);
            end
        end
        testCount++;
        if (sT.size() - stBase != 5) begin
            failCount++;
            $display("[TB] FAIL ovf_small_tx_count: got %0d, required 5", sT.size() - stBase);
        end else begin
            for (int k = 0; k < 5; k++) begin
                testCount++;
                if (sT[stBase + k] !== expT[k]) begin
                    failCount++;
                    $display("[TB] FAIL ovf_small_tx%0d: got %h, required %h", k, sT[stBase + k], expT[k]);
                end
            end
        end
        testCount++;
        if (sErr !== 1'b1 || sDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ovf_small_status: err %b done %b, required 1 0", sErr, sDone);
        end
        testCount++;
        if (bW.size() - bwBase != 5 || bErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ovf_big: writes %0d err %b, required 5 0", bW.size() - bwBase, bErr);
        end
    endtask

    task automatic test_overrun();
        doReset();
        tx_ready = 1'b0;
        driveByte(8'h03);
        driveByte(8'h00);
        driveByte(8'h05);
        tick();
        driveByte(8'h00);
        repeat (3) tick();
        testCount++;
        if (bTxValid !== 1'b1 || bTxData !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL overrun_ack_held: txv %b txd %h, required 1 00", bTxValid, bTxData);
        end
        flush();
        testCount++;
        if (bT.size() - btBase != 2) begin
            failCount++;
            $display("[TB] FAIL overrun_tx_count: got %0d, required 2", bT.size() - btBase);
        end else begin
            testCount++;
            if (bT[btBase] !== 8'h00 || bT[btBase + 1] !== 8'hEE) begin
                failCount++;
                $display("[TB] FAIL overrun_tx_bytes: got %h %h, required 00 ee", bT[btBase], bT[btBase + 1]);
            end
        end
        testCount++;
        if (bErr !== 1'b1 || bDone !== 1'b0 || bW.size() - bwBase != 1) begin
            failCount++;
            $display("[TB] FAIL overrun_status: err %b done %b writes %0d, required 1 0 1", bErr, bDone, bW.size() - bwBase);
        end
    endtask

    task automatic test_reset_events();
        doReset();
        tx_ready = 1'b0;
        driveByte(8'h01);
        driveByte(8'h02);
        driveByte(8'h03);
        tick();
        reset    = 1'b1;
        tx_ready = 1'b1;
        tick();
        testCount++;
        if (bTxValid !== 1'b0 || bWe !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_pending_ack: txv %b we %b, required 0 0", bTxValid, bWe);
        end
        reset = 1'b0;
        markBases();
        repeat (3) tick();
        testCount++;
        if (bT.size() - btBase != 0) begin
            failCount++;
            $display("[TB] FAIL rst_no_transfer: got %0d transfers, required 0", bT.size() - btBase);
        end
        driveByte(8'h04);
        driveByte(8'h00);
        driveByte(8'h01);
        reset = 1'b1;
        tick();
        testCount++;
        if (bWe !== 1'b0 || bTxValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_write_cycle: we %b txv %b, required 0 0", bWe, bTxValid);
        end
        reset = 1'b0;
        markBases();
        stim = '{8'h03, 8'h00, 8'h05};
        applyStimulus(1'b0);
        driveByte(8'h05);
        driveByte(8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        markBases();
        stim = '{8'h00, 8'h00, 8'h07};
        applyStimulus(1'b0);
        flush();
        testCount++;
        if (bW.size() - bwBase != 1 || bT.size() - btBase != 1) begin
            failCount++;
            $display("[TB] FAIL rst_halt_counts: writes %0d acks %0d, required 1 1", bW.size() - bwBase, bT.size() - btBase);
        end else begin
            testCount++;
            if (bW[bwBase] !== 16'h0007 || bA[bwBase] !== 11'd0 || bT[btBase] !== 8'h00) begin
                failCount++;
                $display("[TB] FAIL rst_halt_word: got %h@%0d ack %h, required 0007@0 ack 00", bW[bwBase], bA[bwBase], bT[btBase]);
            end
        end
        testCount++;
        if (bDone !== 1'b1 || bErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_halt_status: done %b err %b, required 1 0", bDone, bErr);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            int nWords;
            doReset();
            readyRandom = 1'b1;
            stim.delete();
            nWords = $urandom_range(1, 7);
            for (int w = 0; w < nWords; w++) begin
                logic [7:0] b0;
                logic [7:0] b1;
                b0 = 8'($urandom_range(1, 7));
                if ($urandom_range(0, 7) == 0) b0 = 8'h00;
                if ($urandom_range(0, 11) == 0) b0 = 8'($urandom_range(8, 255));
                b1 = 8'($urandom_range(0, 7));
                if ($urandom_range(0, 11) == 0) b1 = 8'($urandom_range(8, 255));
                stim.push_back(b0);
                stim.push_back(b1);
                stim.push_back(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                stim.push_back(8'h00);
                stim.push_back(8'($urandom_range(0, 7)));
                stim.push_back(8'($urandom));
            end
            applyStimulus(1'b1);
            flush();
            for (int d = 0; d < 2; d++) begin
                logic [15:0] gotW[$];
                logic [10:0] gotA[$];
                logic [7:0]  gotT[$];
                logic        gotDone;
                logic        gotErr;
                int          wb;
                int          tb;
                if (d == 0) begin
                    modelRun(BIG_DEPTH);
                    gotW = bW; gotA = bA; gotT = bT;
                    gotDone = bDone; gotErr = bErr;
                    wb = bwBase; tb = btBase;
                end else begin
                    modelRun(SMALL_DEPTH);
                    gotW = sW; gotA = sA; gotT = sT;
                    gotDone = sDone; gotErr = sErr;
                    wb = swBase; tb = stBase;
                end
                testCount++;
                if (gotW.size() - wb != mW.size()) begin
                    failCount++;
                    $display("[TB] FAIL rand%0d_dut%0d_writes: got %0d, required %0d", p, d, gotW.size() - wb, mW.size());
                end else begin
                    foreach (mW[k]) begin
                        testCount++;
                        if (gotW[wb + k] !== mW[k] || gotA[wb + k] !== 11'(k)) begin
                            failCount++;
                            $display("[TB] FAIL rand%0d_dut%0d_write%0d: got %h@%0d, required %h@%0d", p, d, k, gotW[wb + k], gotA[wb + k], mW[k], k);
                        end
                    end
                end
                testCount++;
                if (gotT.size() - tb != mT.size()) begin
                    failCount++;
                    $display("[TB] FAIL rand%0d_dut%0d_tx: got %0d bytes, required %0d", p, d, gotT.size() - tb, mT.size());
                end else begin
                    foreach (mT[k]) begin
                        testCount++;
                        if (gotT[tb + k] !== mT[k]) begin
                            failCount++;
                            $display("[TB] FAIL rand%0d_dut%0d_tx%0d: got %h, required %h", p, d, k, gotT[tb + k], mT[k]);
                        end
                    end
                end
                testCount++;
                if ({gotDone, gotErr} !== {mDone, mErr}) begin
                    failCount++;
                    $display("[TB] FAIL rand%0d_dut%0d_status: done/err %b%b, required %b%b", p, d, gotDone, gotErr, mDone, mErr);
                end
            end
        end
    endtask

    // Guard against a hang: report and stop hard.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: run every scenario, then print the summary.
    initial begin
        testCount   = 0;
        failCount   = 0;
        readyRandom = 1'b0;
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        tx_ready    = 1'b0;
        test_reset();
        test_basic_program();
        test_back_to_back();
        test_ack_stall();
        test_invalid_opcode();
        test_overflow();
        test_overrun();
        test_reset_events();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/bip_program_loader.md
# bip_program_loader

Byte-stream program loader for the BIP core: the encoding end of the instruction path whose far end is the instruction decoder. It takes bytes from the UART receiver and packs each 3-byte group into a 16-bit BIP instruction word: a 5-bit opcode and an 11-bit operand. It writes each word sequentially into program memory, acknowledges every word through the UART transmitter, and releases the CPU once a HALT word has been stored.

## Interface
- PROG_DEPTH, 2048, program memory depth in words; must be ≤ 2^ADDR_W
- ADDR_W, 11, program memory address width
- ACK_ERR, 8'hEE, byte transmitted once when the loader enters the error state
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte; valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure
- tx_data  out  8  byte offered to the UART transmitter
- tx_valid  out  1  offer of tx_data; held until accepted
- tx_ready  in  1  transmitter can accept; transfer when tx_valid & tx_ready
- prog_we  out  1  one-cycle program memory write strobe
- prog_addr  out  ADDR_W  write address
- prog_wdata  out  16  instruction word {opcode[4:0], operand[10:0]}
- load_done  out  1  sticky: program loaded, CPU may run
- load_err  out  1  sticky: load aborted

## Operation
- Frame per instruction, 3 bytes in order:
  - B0: opcode. Bits [7:5] must be 0, and the opcode must be ≤ 5'b00111 (HALT, STO, LD, LDI, ADD, ADDI, SUB, SUBI).
  - B1: operand[10:8]. Bits [7:3] must be 0.
  - B2: operand[7:0].
- States and transitions:
  - GET_OP -> GET_HI on a valid B0.
  - GET_HI -> GET_LO on a valid B1.
  - GET_LO -> WRITE on B2.
  - WRITE -> ACK.
  - ACK, after the handshake:
    - -> DONE if the word was HALT.
    - -> ERR_TX if the written address was PROG_DEPTH-1 and the word was not HALT (overflow).
    - -> GET_OP otherwise.
  - ERR_TX -> ERR after the handshake.
  - DONE and ERR are terminal until reset.
- Errors, each going to ERR_TX:
  - invalid B0 in GET_OP;
  - invalid B1 in GET_HI;
  - overflow (see ACK above);
  - rx_valid asserted in WRITE, ACK or ERR_TX (overrun).
- rx_valid in DONE or ERR is ignored.
- HALT carries an operand like any other word. The operand is stored as received and is not checked.
- WRITE: prog_we=1 for exactly one cycle, with prog_addr = current address and prog_wdata = {opcode, operand}. The address increments by 1 at the end of WRITE. It never wraps; overflow is handled by the ACK transition.
- ACK: tx_data = prog_addr[7:0] of the word just written. tx_valid is held until tx_ready.
- ERR_TX: tx_data = ACK_ERR. The loader sends ACK_ERR once, then holds.
- load_done=1 from entry to DONE until reset. load_err=1 from entry to ERR_TX until reset. The two are never both 1.
- prog_we=0 in every state except WRITE.

## Timing
- Reset values:
  - state GET_OP, internal address 0;
  - prog_we, tx_valid, load_done, load_err all 0;
  - prog_addr, prog_wdata, tx_data all 0.
- B2 sampled at edge n: prog_we=1 during cycle n+1; tx_valid=1 from cycle n+2.
- Handshake: the transfer completes on the edge where tx_valid & tx_ready = 1.
  - tx_valid deasserts the following cycle.
  - tx_data stays stable while tx_valid=1.
  - tx_valid never drops before acceptance.
- tx_ready high in the first ACK cycle: the ACK lasts one cycle. B0 of the next word is then accepted from the edge after tx_valid deasserts.
- Fastest throughput: one word per 3 rx strobes plus 2 cycles.
- reset wins over all events in the same cycle, including a pending tx handshake or a prog_we cycle.
  - tx_valid drops on the next edge.
  - No partial word is retained.
- Partial frame interrupted by reset: discarded; nothing is written.

## Test plan
- Load LDI 5 (03 00 05), ADDI 3 (05 00 03), STO 1 (01 00 01), HALT (00 00 00), tx_ready=1 -> writes 16'h1805@0, 16'h2803@1, 16'h0801@2, 16'h0000@3; acks 00,01,02,03; load_done=1; load_err=0.
- Hold tx_ready=0 for 10 cycles during the first ACK -> tx_valid and tx_data=00 stable for all 10 cycles; a single transfer; the next word loads normally.
- Invalid opcode byte 08 -> no write; tx 8'hEE once; load_err=1; later bytes are ignored.
- PROG_DEPTH=4, four non-HALT words -> writes @0..3; acks 00..03; then tx EE; load_err=1; no write at address 4.
- rx_valid during ACK (tx_ready=0) -> tx completes the ack, then EE; load_err=1.
- Reset asserted after B1 of the second word, then a fresh HALT -> HALT written @0; ack 00; load_done=1; load_err=0.
